// File: rtl/fp2int_unit.sv
// IEEE-754 single to signed 32-bit integer converter.
// Iterative one-bit-per-cycle shifter, truncating toward zero with saturation.
module fp2int_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR,
  output logic        ovf,
  output logic        inexact
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mag_q, mag_d;
  logic        sign_q, sign_d;
  logic        left_q, left_d;
  logic        sticky_q, sticky_d;
  logic        ovf_p_q, ovf_p_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        inexact_q, inexact_d;
  logic        done_q, done_d;
  logic [7:0]  exp_w;

  assign exp_w = dataA[30:23];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    left_d    = left_q;
    sticky_d  = sticky_q;
    ovf_p_d   = ovf_p_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d   = dataA[31];
          sticky_d = 1'b0;
          ovf_p_d  = 1'b0;
          left_d   = 1'b0;
          cnt_d    = 5'd0;
          state_d  = FINISH;
          if (exp_w == 8'd255) begin
            ovf_p_d = 1'b1;
            // NaN forces the negative saturation value regardless of sign
            if (dataA[22:0] != 23'd0) begin
              sign_d = 1'b1;
              mag_d  = 32'h8000_0000;
            end else begin
              mag_d = dataA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
          end else if (exp_w == 8'd0 || exp_w < 8'd127) begin
            mag_d    = 32'd0;
            sticky_d = |dataA[30:0];
          end else if (exp_w >= 8'd158) begin
            ovf_p_d = (dataA != 32'hCF00_0000);
            mag_d   = dataA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else begin
            mag_d  = {8'd0, 1'b1, dataA[22:0]};
            left_d = (exp_w > 8'd150);
            cnt_d  = left_d ? (exp_w[4:0] - 5'd22)
                            : (5'd22 - exp_w[4:0]);
            if (cnt_d != 5'd0)
              state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
        if (!left_q)
          sticky_d = sticky_q | mag_q[0];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1)
          state_d = FINISH;
      end
      FINISH: begin
        res_d     = sign_q ? (32'd0 - mag_q) : mag_q;
        ovf_d     = ovf_p_q;
        inexact_d = sticky_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      mag_q     <= 32'd0;
      sign_q    <= 1'b0;
      left_q    <= 1'b0;
      sticky_q  <= 1'b0;
      ovf_p_q   <= 1'b0;
      res_q     <= 32'd0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      left_q    <= left_d;
      sticky_q  <= sticky_d;
      ovf_p_q   <= ovf_p_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign dataR   = res_q;
  assign ovf     = ovf_q;
  assign inexact = inexact_q;

endmodule

// File: doc/fp2int_unit.md
FP2INT_UNIT -- requirements
Module: fp2int_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high, clears all state immediately.
REQ-004 Port start, input, 1 bit: request conversion of dataA; honoured only in IDLE.
REQ-005 Port dataA, input, 32 bits: IEEE-754 single (sign [31], exponent [30:23], fraction [22:0]).
REQ-006 Port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 Port done, output, 1 bit: one-cycle pulse marking a valid new dataR.
REQ-008 Port dataR, output, 32 bits: two's-complement signed integer result.
REQ-009 Port ovf, output, 1 bit: result saturated, or input NaN/Inf; valid with done.
REQ-010 Port inexact, output, 1 bit: nonzero fraction bits discarded; valid with done.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, FINISH.
REQ-012 On a clk edge in IDLE with start=1, the block SHALL capture dataA, set busy=1, and compute e = exp-127 and m = {1, fraction} (24 bits).
REQ-013 Normal case (0 <= e <= 30, exponent not 0 or 255): shift count n = |e-23|, shifting left if e>23 and right if e<23.
REQ-014 If n>0, next state SHALL be SHIFT with counter=n; otherwise next state SHALL be FINISH.
REQ-015 In SHIFT, each edge SHALL shift the magnitude by exactly one bit and decrement the counter; the block SHALL go to FINISH on the edge where the counter goes 1->0.
REQ-016 On a right shift, each bit shifted out SHALL be OR-ed into a sticky bit that becomes inexact.
REQ-017 On the FINISH edge, the block SHALL register dataR (magnitude, negated when sign=1), ovf and inexact, drive done=1 for that one cycle, set busy=0 and go to IDLE.
REQ-018 Total latency SHALL be n+1 edges from the capture edge to done; maximum 24.
REQ-019 Special cases SHALL go directly to FINISH, giving 1-edge latency:
  - Exponent 0 (zero or denormal), or e<0: dataR=0, inexact = (input magnitude != 0).
  - e>=31, positive: dataR=0x7FFFFFFF, ovf=1.
  - e>=31, negative: dataR=0x80000000, ovf=1, except exactly 0xCF000000 (-2^31), which SHALL give ovf=0.
  - Exponent 255, Inf: saturate by sign, ovf=1.
  - Exponent 255, NaN: dataR=0x80000000, ovf=1.
REQ-020 Rounding SHALL truncate toward zero: -4.25 -> -4.
REQ-021 start asserted while busy=1 SHALL be ignored and SHALL NOT alter the operation in progress.
REQ-022 start asserted in the done cycle SHALL be accepted, because the state is IDLE in that cycle.
REQ-023 dataR, ovf and inexact SHALL hold their values until the next done.
REQ-024 Changes on dataA after the capture edge SHALL NOT affect the result.

Reset
REQ-025 While reset=1, the block SHALL force state=IDLE, busy=0, done=0, dataR=0, ovf=0, inexact=0, and clear the counter and shift register.
REQ-026 Reset asserted during SHIFT or FINISH SHALL abort the conversion with no done pulse.
REQ-027 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-028 0x40E00000 (7.0) -> dataR=0x00000007, inexact=0, ovf=0, done 22 edges after capture; busy high throughout.
REQ-029 0xC0880000 (-4.25) -> dataR=0xFFFFFFFC, inexact=1, ovf=0; 0x43FA0000 (500.0) -> dataR=0x000001F4, 16-edge latency.
REQ-030 0x4F000000 -> dataR=0x7FFFFFFF, ovf=1; 0xCF000000 -> dataR=0x80000000, ovf=0; 0x7FC00000 -> dataR=0x80000000, ovf=1; all with 1-edge latency.
REQ-031 0x3F000000 (0.5) -> dataR=0, inexact=1, 1-edge latency; 0x00000000 -> dataR=0, inexact=0.
REQ-032 0x4B000001 -> dataR=0x00800001 after 1 edge; 0x40E00000 with a second start pulsed mid-conversion -> exactly one done, dataR=7; start in the done cycle -> next conversion accepted.
REQ-033 Reset pulsed on the 5th SHIFT cycle of 0x40E00000 -> busy=0, done=0, dataR=0 immediately, no later done; next start with 0x40880000 -> dataR=0x00000004, inexact=1.
